// File: rtl/proc_control.sv
// Multi-cycle processor control unit: fetches into the IR, steps T0..T3 and
// drives register-bank, ALU, immediate and data-memory controls per opcode.
module proc_control #(
  parameter int PC_W = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [15:0]     IR_data,
  input  logic            Gz,
  output logic            IRin,
  output logic [7:0]      Rout,
  output logic [7:0]      Rin,
  output logic            ImmOut,
  output logic [15:0]     Imm,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [2:0]      ALUop,
  output logic            ADDRin,
  output logic            MemRd,
  output logic            MemWr,
  output logic            MemOut,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      curr_stage,
  output logic [3:0]      stage,
  output logic            Done,
  output logic            Illegal
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_MVNZ = 4'b1000;
  localparam logic [3:0] OP_LD   = 4'b1001;
  localparam logic [3:0] OP_SD   = 4'b1010;

  step_e           state_r;
  step_e           next_state_s;
  logic [15:0]     ir_r;
  logic [PC_W-1:0] pc_r;
  logic [3:0]      opcode_s;
  logic [2:0]      rx_s;
  logic [2:0]      ry_s;
  logic            is_alu_s;

  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    onehot8 = 8'b0000_0001 << sel;
  endfunction

  assign opcode_s = ir_r[15:12];
  assign rx_s     = ir_r[11:9];
  assign ry_s     = ir_r[8:6];
  assign is_alu_s = (opcode_s >= 4'b0010) && (opcode_s <= 4'b0111);
  assign Imm      = {7'b000_0000, ir_r[8:0]};
  assign pc       = pc_r;

  // Step decode: controls and next step; Reset or a frozen Run silences every enable.
  always_comb begin
    next_state_s = state_r;
    IRin    = 1'b0;
    Rout    = 8'b0000_0000;
    Rin     = 8'b0000_0000;
    ImmOut  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    ALUop   = 3'b000;
    ADDRin  = 1'b0;
    MemRd   = 1'b0;
    MemWr   = 1'b0;
    MemOut  = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;
    if (Reset) begin
      next_state_s = T0;
    end else if (!Run) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        T0: begin
          IRin         = 1'b1;
          next_state_s = T1;
        end
        T1: begin
          next_state_s = T2;
          if (is_alu_s) begin
            Rout = onehot8(rx_s);
            Ain  = 1'b1;
          end else begin
            case (opcode_s)
              OP_MV: begin
                Rout = onehot8(ry_s);
                Rin  = onehot8(rx_s);
                Done = 1'b1;
              end
              OP_MVI: begin
                ImmOut = 1'b1;
                Rin    = onehot8(rx_s);
                Done   = 1'b1;
              end
              OP_MVNZ: begin
                Done = 1'b1;
                if (Gz) begin
                  Rout = onehot8(ry_s);
                  Rin  = onehot8(rx_s);
                end else begin
                  Rout = 8'b0000_0000;
                  Rin  = 8'b0000_0000;
                end
              end
              OP_LD, OP_SD: begin
                Rout   = onehot8(ry_s);
                ADDRin = 1'b1;
              end
              default: begin
                Done    = 1'b1;
                Illegal = 1'b1;
              end
            endcase
            if (Done) begin
              next_state_s = T0;
            end else begin
              next_state_s = T2;
            end
          end
        end
        T2: begin
          next_state_s = T3;
          if (is_alu_s) begin
            Rout  = onehot8(ry_s);
            Gin   = 1'b1;
            ALUop = opcode_s[2:0] - 3'd2;
          end else begin
            case (opcode_s)
              OP_LD: MemRd = 1'b1;
              OP_SD: begin
                Rout         = onehot8(rx_s);
                MemWr        = 1'b1;
                Done         = 1'b1;
                next_state_s = T0;
              end
              default: next_state_s = T0;
            endcase
          end
        end
        T3: begin
          next_state_s = T0;
          if (is_alu_s) begin
            Gout = 1'b1;
            Rin  = onehot8(rx_s);
            Done = 1'b1;
          end else if (opcode_s == OP_LD) begin
            MemOut = 1'b1;
            Rin    = onehot8(rx_s);
            Done   = 1'b1;
          end else begin
            Done = 1'b0;
          end
        end
        default: next_state_s = T0;
      endcase
    end
  end

  // Step indicators; Reset shows T0 immediately.
  always_comb begin
    if (Reset) begin
      curr_stage = 2'd0;
    end else begin
      curr_stage = state_r;
    end
    case (curr_stage)
      2'd0:    stage = 4'b1000;
      2'd1:    stage = 4'b0100;
      2'd2:    stage = 4'b0010;
      2'd3:    stage = 4'b0001;
      default: stage = 4'b1000;
    endcase
  end

  // State, IR and pc registers; pc advances on the edge that ends a Done step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= T0;
      ir_r    <= 16'h0000;
      pc_r    <= {PC_W{1'b0}};
    end else if (Run) begin
      state_r <= next_state_s;
      if (IRin) begin
        ir_r <= IR_data;
      end
      if (Done) begin
        pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// Directed self-checking bench for proc_control with hand-computed expectations.
module tb_proc_control;

  logic        Clock = 1'b0;
  logic        Reset, Run, Gz;
  logic [15:0] IR_data;
  logic        IRin, ImmOut, Ain, Gin, Gout, ADDRin, MemRd, MemWr, MemOut, Done, Illegal;
  logic [7:0]  Rout, Rin;
  logic [15:0] Imm;
  logic [2:0]  ALUop;
  logic [3:0]  pc;
  logic [1:0]  curr_stage;
  logic [3:0]  stage;

  int n_cmp = 0;
  int n_mis = 0;

  proc_control #(.PC_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IR_data(IR_data), .Gz(Gz),
    .IRin(IRin), .Rout(Rout), .Rin(Rin), .ImmOut(ImmOut), .Imm(Imm),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .ALUop(ALUop), .ADDRin(ADDRin),
    .MemRd(MemRd), .MemWr(MemWr), .MemOut(MemOut), .pc(pc),
    .curr_stage(curr_stage), .stage(stage), .Done(Done), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; Gz = 1'b0; IR_data = 16'h0000;
    tick(); tick();
    check("rst_stage", stage, 4'b1000);
    check("rst_curr", curr_stage, 2'd0);
    check("rst_pc", pc, 4'd0);
    check("rst_irin", IRin, 1'b0);
    check("rst_done", Done, 1'b0);

    // mvi R2,5
    Reset = 1'b0; IR_data = 16'h1405; #1;
    check("mvi_t0_irin", IRin, 1'b1);
    tick();
    check("mvi_stage", stage, 4'b0100);
    check("mvi_immout", ImmOut, 1'b1);
    check("mvi_imm", Imm, 16'h0005);
    check("mvi_rin", Rin, 8'b0000_0100);
    check("mvi_done", Done, 1'b1);
    check("mvi_illegal", Illegal, 1'b0);
    tick();
    check("mvi_pc", pc, 4'd1);
    check("mvi_next_stage", stage, 4'b1000);

    // add R2,R3
    IR_data = 16'h24C0;
    tick();
    check("add_t1_rout", Rout, 8'b0000_0100);
    check("add_t1_ain", Ain, 1'b1);
    check("add_t1_done", Done, 1'b0);
    tick();
    check("add_t2_rout", Rout, 8'b0000_1000);
    check("add_t2_gin", Gin, 1'b1);
    check("add_t2_aluop", ALUop, 3'b000);
    tick();
    check("add_t3_gout", Gout, 1'b1);
    check("add_t3_rin", Rin, 8'b0000_0100);
    check("add_t3_done", Done, 1'b1);
    check("add_t3_curr", curr_stage, 2'd3);
    tick();
    check("add_pc", pc, 4'd2);
    check("add_stage", stage, 4'b1000);

    // sd R3,R1
    IR_data = 16'hA640;
    tick();
    check("sd_t1_rout", Rout, 8'b0000_0010);
    check("sd_t1_addrin", ADDRin, 1'b1);
    tick();
    check("sd_t2_rout", Rout, 8'b0000_1000);
    check("sd_t2_memwr", MemWr, 1'b1);
    check("sd_t2_memrd", MemRd, 1'b0);
    check("sd_t2_done", Done, 1'b1);
    tick();
    check("sd_pc", pc, 4'd3);

    // ld R0,R4
    IR_data = 16'h9100;
    tick();
    check("ld_t1_rout", Rout, 8'b0001_0000);
    check("ld_t1_addrin", ADDRin, 1'b1);
    tick();
    check("ld_t2_memrd", MemRd, 1'b1);
    check("ld_t2_memwr", MemWr, 1'b0);
    check("ld_t2_rout", Rout, 8'b0000_0000);
    check("ld_t2_rin", Rin, 8'b0000_0000);
    check("ld_t2_done", Done, 1'b0);
    tick();
    check("ld_t3_memout", MemOut, 1'b1);
    check("ld_t3_rin", Rin, 8'b0000_0001);
    check("ld_t3_done", Done, 1'b1);
    tick();
    check("ld_pc", pc, 4'd4);

    // mvnz R1,R2 with Gz=0 then Gz=1
    IR_data = 16'h8280; Gz = 1'b0;
    tick();
    check("mvnz0_done", Done, 1'b1);
    check("mvnz0_rin", Rin, 8'b0000_0000);
    check("mvnz0_rout", Rout, 8'b0000_0000);
    tick();
    Gz = 1'b1;
    tick();
    check("mvnz1_rout", Rout, 8'b0000_0100);
    check("mvnz1_rin", Rin, 8'b0000_0010);
    check("mvnz1_done", Done, 1'b1);
    tick();
    check("mvnz_pc", pc, 4'd6);
    Gz = 1'b0;

    // sub R1,R2 with Run dropped in T2
    IR_data = 16'h3298;
    tick();
    check("sub_t1_rout", Rout, 8'b0000_0010);
    tick();
    check("sub_t2_gin", Gin, 1'b1);
    check("sub_t2_aluop", ALUop, 3'b001);
    Run = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("hold_gin", Gin, 1'b0);
      check("hold_rout", Rout, 8'b0000_0000);
      check("hold_aluop", ALUop, 3'b000);
      check("hold_stage", stage, 4'b0010);
      tick();
    end
    Run = 1'b1; #1;
    check("resume_gin", Gin, 1'b1);
    check("resume_aluop", ALUop, 3'b001);
    check("resume_rout", Rout, 8'b0000_0100);
    tick();
    check("sub_t3_rin", Rin, 8'b0000_0010);
    check("sub_t3_done", Done, 1'b1);
    tick();
    check("sub_pc", pc, 4'd7);

    // Reset asserted in T2 of add
    IR_data = 16'h24C0;
    tick(); tick();
    check("rst_t2_stage_pre", stage, 4'b0010);
    Reset = 1'b1; #1;
    check("rst_t2_gin", Gin, 1'b0);
    check("rst_t2_rout", Rout, 8'b0000_0000);
    check("rst_t2_stage", stage, 4'b1000);
    tick();
    Reset = 1'b0; IR_data = 16'hF000; #1;
    check("rst_after_stage", stage, 4'b1000);
    check("rst_after_pc", pc, 4'd0);
    check("rst_after_rin", Rin, 8'b0000_0000);
    check("rst_after_illegal", Illegal, 1'b0);

    // Illegal opcode
    tick();
    check("ill_illegal", Illegal, 1'b1);
    check("ill_done", Done, 1'b1);
    check("ill_rin", Rin, 8'b0000_0000);
    check("ill_rout", Rout, 8'b0000_0000);
    tick();
    check("ill_pc", pc, 4'd1);

    // pc wrap
    IR_data = 16'h1000;
    for (int i = 0; i < 14; i++) begin
      tick(); tick();
    end
    check("wrap_pre_pc", pc, 4'd15);
    tick();
    check("wrap_done", Done, 1'b1);
    tick();
    check("wrap_pc", pc, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/proc_control.md
# proc_control

Control unit that sequences the multi-cycle processor datapath: it fetches 16-bit instructions, holds them in an instruction register, and steps through time steps T0–T3. Each step drives the one-hot register-bank selects, ALU/G register enables, immediate path, data-memory strobes and the `Done` pulse. It replaces the inline step counter in the processor, so the register bank, ALU and memories become pure datapath driven only by this block.

## Interface
Parameters:
- `PC_W`, 4: program-counter width (instruction memory depth 2^PC_W).

Ports:
- `Clock` in 1: single clock, all state updates on rising edge.
- `Reset` in 1: synchronous, active-high; dominates every other input.
- `Run` in 1: 1 = advance one step per cycle; 0 = freeze.
- `IR_data` in 16: instruction memory word at `pc` (combinational read).
- `Gz` in 1: 1 when the G register is non-zero (for mvnz).
- `IRin` out 1: instruction register loads `IR_data` (T0).
- `Rout` out 8: one-hot register-bank read select onto the bus.
- `Rin` out 8: one-hot register-bank write enable.
- `ImmOut` out 1: drive `Imm` onto the bus.
- `Imm` out 16: zero-extended {IR[8:6], IR[5:0]}.
- `Ain`, `Gin`, `Gout` out 1 each: A load, G load, G onto bus.
- `ALUop` out 3: 000 add, 001 sub, 010 and, 011 slt, 100 sll, 101 srl.
- `ADDRin` out 1: memory address register loads the bus.
- `MemRd`, `MemWr`, `MemOut` out 1 each: data-memory read, write (data = bus), read data onto bus.
- `pc` out PC_W: instruction address.
- `curr_stage` out 2: current step 0–3.
- `stage` out 4: one-hot step, T0=1000, T1=0100, T2=0010, T3=0001.
- `Done` out 1: last step of the current instruction.
- `Illegal` out 1: unsupported opcode in T1.

## Operation
- Fields of the latched IR: opcode [15:12], rX [11:9], rY [8:6], imm [5:0].
- States T0→T1→T2→T3. After any step with `Done`=1, the next state is T0.
- T0, all opcodes: `IRin`=1.
- mv (0000): T1 `Rout`=rY, `Rin`=rX, `Done`.
- mvi (0001): T1 `ImmOut`, `Rin`=rX, `Done`.
- ALU ops add/sub/and/slt/sll/srl (0010–0111):
  - T1 `Rout`=rX, `Ain`.
  - T2 `Rout`=rY, `Gin`, `ALUop` per opcode.
  - T3 `Gout`, `Rin`=rX, `Done`.
- mvnz (1000): T1 `Done`. If `Gz`=1, also `Rout`=rY and `Rin`=rX; otherwise no enables.
- ld (1001):
  - T1 `Rout`=rY, `ADDRin`.
  - T2 `MemRd`.
  - T3 `MemOut`, `Rin`=rX, `Done`.
- sd (1010): T1 `Rout`=rY, `ADDRin`; T2 `Rout`=rX, `MemWr`, `Done`.
- Opcodes 1011–1111: T1 `Done`=1, `Illegal`=1, no other enables.
- `ALUop` is 000 in every step other than ALU-op T2.
- `pc` increments on the clock edge that ends a `Done` step and wraps from 2^PC_W−1 to 0.
- Run=0: state, IR and pc hold. All enables, `Done` and `Illegal` are 0. `stage`/`curr_stage` keep showing the frozen step.

## Timing
- Controls are combinational from (state, IR, `Gz`, `Run`, `Reset`). State, IR and pc are registered.
- Latency with Run held high, counted in cycles including T0: mv/mvi/mvnz/illegal 2; sd 3; ALU ops and ld 4.
- Reset high at an edge: state=T0, IR=0, pc=0.
- While Reset is high, all enables, `Done` and `Illegal` are forced to 0. `stage`=1000, `curr_stage`=0.
- Reset mid-instruction aborts it; no partial write is issued after the reset edge.
- Reset and Run together: reset wins.
- `Rout`/`Rin` are always one-hot or zero, never multi-hot.
- `MemRd` and `MemWr` are never high in the same cycle.

## Test plan
- **mvi:** Reset, then Run=1, `IR_data`=0x1405 (mvi R2,5).
  - T0 `IRin`=1.
  - T1 `ImmOut`=1, `Imm`=0x0005, `Rin`=00000100, `Done`=1.
  - Next cycle `pc`=1, `stage`=1000.
- **add:** `IR_data`=0x24C0 (add R2,R3).
  - T1 `Rout`=00000100, `Ain`.
  - T2 `Rout`=00001000, `Gin`, `ALUop`=000.
  - T3 `Gout`, `Rin`=00000100, `Done`.
  - 4 cycles total.
- **sd, then ld:**
  - 0xA640 (sd R3,R1): T1 `Rout`=00000010, `ADDRin`; T2 `Rout`=00001000, `MemWr`, `Done`.
  - 0x9100 (ld R0,R4): T2 `MemRd` alone; T3 `MemOut`, `Rin`=00000001.
- **mvnz:** 0x8280 (mvnz R1,R2).
  - With `Gz`=0: `Done` in T1, `Rin`=0.
  - With `Gz`=1: `Rout`=00000100, `Rin`=00000010.
- **Run/Reset:**
  - Drop Run during sub T2 for 3 cycles: outputs are 0, `stage` stays 0010; on resume, T2 enables reappear, then T3 follows.
  - Assert Reset in T2: next cycle `stage`=1000, `pc`=0, no `Rin`.
- **Illegal and wrap:**
  - `IR_data`=0xF000: `Illegal`=1, `Done`=1 in T1.
  - Preload `pc`=15 via 15 single-step instructions; next `Done` wraps `pc` to 0.
